// File: rtl/pick_input_ctrl.sv
// pick_input_ctrl
// Turns per-frame HID keycodes into the pick-mode flag and the 3-bit LRdir
// command for the pick-motion stage. A mode key press edge toggles pick mode,
// subject to a cooldown window. Holding LEFT starts slow leftward motion, and
// after HOLD_FRAMES consecutive frames it becomes fast motion.
// State, hold counter, pickMode and LRdir are all flops, so every output is
// registered.
//
// Handshake: none. Keycodes are sampled once per frame on the rising edge of
// frame_clk, with no valid/ready qualification. Slot value 00 means no key.
module pick_input_ctrl #(
  parameter logic [7:0] KEY_MODE    = 8'h08,
  parameter logic [7:0] KEY_LEFT    = 8'h04,
  parameter int         HOLD_FRAMES = 30,
  parameter int         COOLDOWN    = 15
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic       pickMode,
  output logic [2:0] LRdir,
  output logic [1:0] ctrl_state,
  output logic [5:0] hold_cnt
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_READY = 2'd1,
    ST_SLOW  = 2'd2,
    ST_FAST  = 2'd3
  } state_t;

  localparam logic [5:0] HOLD_LAST = 6'(HOLD_FRAMES - 1);
  localparam logic [4:0] COOL_LOAD = 5'(COOLDOWN);

  localparam logic [2:0] DIR_STOP = 3'b000;
  localparam logic [2:0] DIR_SLOW = 3'b001;
  localparam logic [2:0] DIR_FAST = 3'b010;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] hold_d;
  logic [4:0] cool_q;
  logic [4:0] cool_d;
  logic       mode_prev;
  logic       mode_now;
  logic       left_now;
  logic       mode_edge;
  logic       pick_d;
  logic [2:0] dir_d;

  // Decode the two key slots and qualify the mode press edge with the cooldown.
  always_comb begin
    mode_now  = (keycode0 == KEY_MODE) | (keycode1 == KEY_MODE);
    left_now  = (keycode0 == KEY_LEFT) | (keycode1 == KEY_LEFT);
    mode_edge = mode_now & ~mode_prev & (cool_q == 5'd0);
  end

  // Cooldown reloads on an accepted toggle, otherwise counts down to zero.
  always_comb begin
    cool_d = cool_q;
    if (mode_edge) begin
      cool_d = COOL_LOAD;
    end else if (cool_q != 5'd0) begin
      cool_d = cool_q - 5'd1;
    end
  end

  // Next-state and hold counter. The mode edge wins over LEFT in the same
  // frame. Any entry to OFF or READY clears the counter.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_cnt;
    case (state_q)
      ST_OFF: begin
        hold_d = 6'd0;
        if (mode_edge) state_d = ST_READY;
      end
      ST_READY: begin
        hold_d = 6'd0;
        if (mode_edge) begin
          state_d = ST_OFF;
        end else if (left_now) begin
          state_d = ST_SLOW;
        end
      end
      ST_SLOW: begin
        if (mode_edge) begin
          state_d = ST_OFF;
          hold_d  = 6'd0;
        end else if (!left_now) begin
          state_d = ST_READY;
          hold_d  = 6'd0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_d = ST_FAST;
        end else begin
          hold_d = hold_cnt + 6'd1;
        end
      end
      ST_FAST: begin
        if (mode_edge) begin
          state_d = ST_OFF;
          hold_d  = 6'd0;
        end else if (!left_now) begin
          state_d = ST_READY;
          hold_d  = 6'd0;
        end
      end
      default: begin
        state_d = ST_OFF;
        hold_d  = 6'd0;
      end
    endcase
  end

  // Output decode of the next state, so the registered outputs line up with the state register.
  always_comb begin
    pick_d = 1'b0;
    dir_d  = DIR_STOP;
    case (state_d)
      ST_OFF:   begin pick_d = 1'b0; dir_d = DIR_STOP; end
      ST_READY: begin pick_d = 1'b1; dir_d = DIR_STOP; end
      ST_SLOW:  begin pick_d = 1'b1; dir_d = DIR_SLOW; end
      ST_FAST:  begin pick_d = 1'b1; dir_d = DIR_FAST; end
      default:  begin pick_d = 1'b0; dir_d = DIR_STOP; end
    endcase
  end

  // State, counters and outputs. mode_prev resets high so that a mode key
  // held through reset does not count as a fresh press.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_OFF;
      hold_cnt  <= 6'd0;
      cool_q    <= 5'd0;
      mode_prev <= 1'b1;
      pickMode  <= 1'b0;
      LRdir     <= DIR_STOP;
    end else begin
      state_q   <= state_d;
      hold_cnt  <= hold_d;
      cool_q    <= cool_d;
      mode_prev <= mode_now;
      pickMode  <= pick_d;
      LRdir     <= dir_d;
    end
  end

  assign ctrl_state = state_q;

endmodule
